// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment display path (scan mux and number encoder).
package seg7_pkg;

   localparam int unsigned SEG7_DIGIT_W         = 4;
   localparam int unsigned SEG7_MAX_DIGITS      = 8;
   localparam int unsigned SEG7_NUM_DIGITS_DEF  = 4;
   localparam int unsigned SEG7_REFRESH_DIV_DEF = 50000;

   // Slice the low NUM_DIGITS bits for an all-digits-off select pattern.
   localparam logic [SEG7_MAX_DIGITS-1:0] SEG7_SEL_OFF = '1;

endpackage

// File: rtl/seg7_refresh_tick.sv
// Free-running prescaler: counts 0..REFRESH_DIV-1 and flags the last count as tick.
module seg7_refresh_tick
   import seg7_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = SEG7_REFRESH_DIV_DEF
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int unsigned   CW   = $clog2(REFRESH_DIV);
   localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (r_cnt == LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign tick = (r_cnt == LAST);

endmodule

// File: rtl/seg7_scan_mux.sv
// Multi-digit 7-segment scanner with frame-aligned value updates.
// Optional leading-zero blanking: define SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_mux
   import seg7_pkg::*;
#(
   parameter int unsigned NUM_DIGITS  = SEG7_NUM_DIGITS_DEF,
   parameter int unsigned REFRESH_DIV = SEG7_REFRESH_DIV_DEF
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [SEG7_DIGIT_W*NUM_DIGITS-1:0] in_value,
   input  logic                               in_valid,
   output logic                               in_ready,
   output logic [SEG7_DIGIT_W-1:0]            digit_num,
   output logic [NUM_DIGITS-1:0]              digit_sel,
   output logic                               frame_start
);

   localparam int unsigned   VW   = SEG7_DIGIT_W * NUM_DIGITS;
   localparam int unsigned   IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);

   logic                    w_tick;
   logic                    w_boundary;
   logic                    w_xfer;
   logic [IW-1:0]           w_idx_next;
   logic [VW-1:0]           w_active_next;
   logic [SEG7_DIGIT_W-1:0] w_num_next;
   logic [NUM_DIGITS-1:0]   w_blank;
   logic [NUM_DIGITS-1:0]   w_sel_lit;

   logic [VW-1:0]           r_active;
   logic [VW-1:0]           r_pending;
   logic                    r_pending_vld;
   logic [IW-1:0]           r_idx;
   logic [SEG7_DIGIT_W-1:0] r_digit_num;
   logic [NUM_DIGITS-1:0]   r_digit_sel;
   logic                    r_frame_start;

   seg7_refresh_tick #(
      .REFRESH_DIV (REFRESH_DIV)
   ) u_refresh_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (w_tick)
   );

   always_comb begin
      w_boundary    = w_tick && (r_idx == LAST);
      // Capture is blocked while pending is full, so it can never coincide with a commit.
      w_xfer        = in_valid && !r_pending_vld;
      w_idx_next    = (r_idx == LAST) ? '0 : r_idx + 1'b1;
      w_active_next = (w_boundary && r_pending_vld) ? r_pending : r_active;
      w_num_next    = SEG7_DIGIT_W'(w_active_next >> (SEG7_DIGIT_W * w_idx_next));
   end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
   always_comb begin
      w_blank = '0;
      for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
         w_blank[i] = ((r_active >> (SEG7_DIGIT_W * i)) == '0);
      end
   end
`else
   assign w_blank = '0;
`endif

   assign w_sel_lit = ~(NUM_DIGITS'(1) << r_idx) | w_blank;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_active      <= '0;
         r_pending     <= '0;
         r_pending_vld <= 1'b0;
         r_idx         <= '0;
         r_digit_num   <= '0;
         r_digit_sel   <= SEG7_SEL_OFF[NUM_DIGITS-1:0];
         r_frame_start <= 1'b0;
      end else begin
         r_frame_start <= w_boundary;
         r_active      <= w_active_next;
         if (w_boundary && r_pending_vld) begin
            r_pending_vld <= 1'b0;
         end else if (w_xfer) begin
            r_pending     <= in_value;
            r_pending_vld <= 1'b1;
         end
         // Slot change: new nibble now, anode one edge later to match the encoder register.
         if (w_tick) begin
            r_idx       <= w_idx_next;
            r_digit_num <= w_num_next;
            r_digit_sel <= SEG7_SEL_OFF[NUM_DIGITS-1:0];
         end else begin
            r_digit_sel <= w_sel_lit;
         end
      end
   end

   assign in_ready    = !r_pending_vld;
   assign digit_num   = r_digit_num;
   assign digit_sel   = r_digit_sel;
   assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Self-checking bench for seg7_scan_mux with a cycle-count based reference model.
module tb_seg7_scan_mux;

   localparam int unsigned ND = 4;
   localparam int unsigned RD = 4;
   localparam int unsigned FR = ND * RD;

   logic        clk;
   logic        rst_n;
   logic [15:0] in_value;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  digit_num;
   logic [3:0]  digit_sel;
   logic        frame_start;

   int unsigned n_vec;
   int unsigned n_err;

   // Reference model: edges since reset, displayed value, one-deep pending slot.
   int unsigned m_t;
   logic [15:0] m_active;
   logic [15:0] m_pending;
   logic        m_pvld;

   seg7_scan_mux #(
      .NUM_DIGITS  (ND),
      .REFRESH_DIV (RD)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_value    (in_value),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .digit_num   (digit_num),
      .digit_sel   (digit_sel),
      .frame_start (frame_start)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_t       <= 0;
         m_active  <= '0;
         m_pending <= '0;
         m_pvld    <= 1'b0;
      end else begin
         m_t <= m_t + 1;
         if ((m_t % FR) == FR - 1 && m_pvld) begin
            m_active <= m_pending;
            m_pvld   <= 1'b0;
         end else if (in_valid && !m_pvld) begin
            m_pending <= in_value;
            m_pvld    <= 1'b1;
         end
      end
   end

   // Expected {digit_sel, digit_num, frame_start, in_ready} after m_t edges.
   function automatic logic [9:0] exp_pack();
      int unsigned idx;
      logic [3:0]  sel;
      logic [3:0]  num;
      logic        fs;
      idx = (m_t / RD) % ND;
      num = 4'((m_active >> (4 * idx)) & 16'h000F);
      sel = ~(4'b0001 << idx);
      if ((m_t % RD) == 0) sel = 4'hF;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (idx != 0 && (m_active >> (4 * idx)) == 16'h0000) sel = 4'hF;
`endif
      fs = (m_t != 0) && ((m_t % FR) == 0);
      return {sel, num, fs, !m_pvld};
   endfunction

   task automatic wait_ready(input int unsigned budget);
      int unsigned n;
      n = 0;
      while (!in_ready && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      n_vec++;
      if (!in_ready) begin
         n_err++;
         $display("FAIL wait_ready: in_ready=%0b after %0d cycles, required 1", in_ready, budget);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_value = '0;
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if ({digit_sel, digit_num, frame_start, in_ready} !== {4'hF, 4'h0, 1'b0, 1'b1}) begin
         n_err++;
         $display("FAIL reset_hold: got %b, required %b",
                  {digit_sel, digit_num, frame_start, in_ready}, {4'hF, 4'h0, 1'b0, 1'b1});
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_vec++;
      if (digit_sel !== 4'b1110 || digit_num !== 4'h0) begin
         n_err++;
         $display("FAIL first_edge: sel=%b num=%h, required sel=1110 num=0", digit_sel, digit_num);
      end
      in_value = 16'h7A3C; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (22) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      n_vec++;
      if ({digit_sel, digit_num, frame_start, in_ready} !== {4'hF, 4'h0, 1'b0, 1'b1}) begin
         n_err++;
         $display("FAIL reset_async: got %b, required %b",
                  {digit_sel, digit_num, frame_start, in_ready}, {4'hF, 4'h0, 1'b0, 1'b1});
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_scan();
      logic [3:0] digs [4];
      logic [3:0] sel_e;
      int unsigned fs_cnt;
      digs[0] = 4'h4; digs[1] = 4'h3; digs[2] = 4'h2; digs[3] = 4'h1;
      wait_ready(40);
      in_value = 16'h1234; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_ready(40);
      n_vec++;
      if (frame_start !== 1'b1) begin
         n_err++;
         $display("FAIL scan_commit_fs: frame_start=%b on commit edge, required 1", frame_start);
      end
      for (int j = 0; j < 16; j++) begin
         sel_e = ((j % 4) == 0) ? 4'hF : ~(4'b0001 << (j / 4));
         n_vec++;
         if (digit_num !== digs[j / 4] || digit_sel !== sel_e) begin
            n_err++;
            $display("FAIL scan_slot%0d: num=%h sel=%b, required num=%h sel=%b",
                     j, digit_num, digit_sel, digs[j / 4], sel_e);
         end
         @(posedge clk); #1;
      end
      fs_cnt = 0;
      for (int j = 0; j < 32; j++) begin
         if (frame_start === 1'b1) fs_cnt++;
         @(posedge clk); #1;
      end
      n_vec++;
      if (fs_cnt != 2) begin
         n_err++;
         $display("FAIL scan_fs_rate: %0d pulses in 32 cycles, required 2", fs_cnt);
      end
   endtask

   task automatic test_handshake();
      int unsigned n;
      wait_ready(40);
      in_value = 16'hABCD; in_valid = 1'b1;
      @(posedge clk); #1;
      n_vec++;
      if (in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL hs_accept: in_ready=%b after accept, required 0", in_ready);
      end
      in_value = 16'h5555;
      n = 0;
      while (!in_ready && n < 40) begin
         n_vec++;
         if ({digit_sel, digit_num, frame_start, in_ready} !== exp_pack()) begin
            n_err++;
            $display("FAIL hs_hold: got %b, required %b",
                     {digit_sel, digit_num, frame_start, in_ready}, exp_pack());
         end
         @(posedge clk); #1;
         n++;
      end
      n_vec++;
      if (in_ready !== 1'b1 || frame_start !== 1'b1 || digit_num !== 4'hD) begin
         n_err++;
         $display("FAIL hs_commit: rdy=%b fs=%b num=%h, required rdy=1 fs=1 num=d",
                  in_ready, frame_start, digit_num);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_vec++;
      if (in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL hs_second_accept: in_ready=%b, required 0", in_ready);
      end
      repeat (20) begin
         n_vec++;
         if ({digit_sel, digit_num, frame_start, in_ready} !== exp_pack()) begin
            n_err++;
            $display("FAIL hs_display: got %b, required %b",
                     {digit_sel, digit_num, frame_start, in_ready}, exp_pack());
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_collision();
      int unsigned n;
      wait_ready(40);
      n = 0;
      while ((m_t % FR) != FR - 1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      in_value = 16'h0009; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_vec++;
      if (frame_start !== 1'b1 || in_ready !== 1'b0 || digit_num !== 4'h5) begin
         n_err++;
         $display("FAIL coll_boundary: fs=%b rdy=%b num=%h, required fs=1 rdy=0 num=5",
                  frame_start, in_ready, digit_num);
      end
      for (int j = 1; j < 16; j++) begin
         @(posedge clk); #1;
         n_vec++;
         if ({digit_sel, digit_num, frame_start, in_ready} !== exp_pack()) begin
            n_err++;
            $display("FAIL coll_old_frame: got %b, required %b",
                     {digit_sel, digit_num, frame_start, in_ready}, exp_pack());
         end
      end
      @(posedge clk); #1;
      n_vec++;
      if (frame_start !== 1'b1 || digit_num !== 4'h9 || in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL coll_commit: fs=%b num=%h rdy=%b, required fs=1 num=9 rdy=1",
                  frame_start, digit_num, in_ready);
      end
   endtask

   task automatic test_blank();
      logic [15:0] vals [2];
      logic [3:0]  seen;
      logic [3:0]  req;
      vals[0] = 16'h0042; vals[1] = 16'h0000;
      for (int k = 0; k < 2; k++) begin
         wait_ready(40);
         in_value = vals[k]; in_valid = 1'b1;
         @(posedge clk); #1;
         in_valid = 1'b0;
         wait_ready(40);
         seen = 4'h0;
         repeat (16) begin
            seen = seen | ~digit_sel;
            @(posedge clk); #1;
         end
`ifdef SEG7_LEADING_ZERO_BLANK_EN
         req = (k == 0) ? 4'b0011 : 4'b0001;
`else
         req = 4'b1111;
`endif
         n_vec++;
         if (seen !== req) begin
            n_err++;
            $display("FAIL blank_%h: lit mask %b, required %b", vals[k], seen, req);
         end
      end
   endtask

   task automatic test_random();
      repeat (320) begin
         in_valid = ($urandom_range(0, 3) == 0);
         in_value = 16'($urandom);
         @(posedge clk); #1;
         n_vec++;
         if ({digit_sel, digit_num, frame_start, in_ready} !== exp_pack()) begin
            n_err++;
            $display("FAIL random t=%0d: got %b, required %b",
                     m_t, {digit_sel, digit_num, frame_start, in_ready}, exp_pack());
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset_pending();
      logic fail;
      wait_ready(40);
      in_value = 16'hBEEF; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_vec++;
      if (in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL rp_pending: in_ready=%b, required 0", in_ready);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (in_ready !== 1'b1 || digit_sel !== 4'hF) begin
         n_err++;
         $display("FAIL rp_reset: rdy=%b sel=%b, required rdy=1 sel=1111", in_ready, digit_sel);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      fail = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (digit_num !== 4'h0 || in_ready !== 1'b1) fail = 1'b1;
      end
      n_vec++;
      if (fail) begin
         n_err++;
         $display("FAIL rp_discard: num=%h rdy=%b seen nonzero/busy, required num=0 rdy=1",
                  digit_num, in_ready);
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      test_reset();
      test_scan();
      test_handshake();
      test_collision();
      test_blank();
      test_random();
      test_reset_pending();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
